// File: rtl/key_pulse_gen.sv
// Debounced key front end: one-cycle press pulse plus optional auto-repeat, and a debounced level.
// Latency: DEBOUNCE_CYCLES+2 edges from pin to pulse/key_state; no backpressure, pulses are fire-and-forget.
module key_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 25_000_000,
    parameter int REPEAT_CYCLES   = 5_000_000,
    parameter int CNT_W           = 25,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    input  logic repeat_en,
    output logic pulse,
    output logic key_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam logic             C_INV    = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_tmr;
    logic             r_pulse;
    logic             r_key_state;
    logic [CNT_W-1:0] w_db_cnt_nxt;
    logic [CNT_W-1:0] w_tmr_nxt;
    logic             w_pulse_nxt;
    logic             w_key_state_nxt;
    logic             w_differ;
    logic             w_db_done;
    logic             w_hold_due;
    logic             w_rep_due;

    // Normalise polarity before the synchroniser so 1 always means pressed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_in ^ C_INV;
            r_sync2 <= r_sync1;
        end
    end

    assign w_differ   = (r_sync2 != r_key_state);
    assign w_db_done  = w_differ && (r_db_cnt == DB_LAST);
    assign w_hold_due = repeat_en && (r_tmr == HOLD_LAST);
    assign w_rep_due  = repeat_en && (r_tmr == REP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Release acceptance outranks any repeat falling due on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_db_done) begin
                    w_state_nxt = ST_HELD;
                end
            end
            ST_HELD: begin
                if (w_db_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_hold_due) begin
                    w_state_nxt = ST_REPEAT;
                end
            end
            ST_REPEAT: begin
                if (w_db_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (!repeat_en) begin
                    w_state_nxt = ST_HELD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_db_cnt_nxt    = (w_differ && !w_db_done) ? (r_db_cnt + C_ONE) : '0;
        w_tmr_nxt       = '0;
        w_pulse_nxt     = 1'b0;
        w_key_state_nxt = r_key_state;
        case (r_state)
            ST_IDLE: begin
                if (w_db_done) begin
                    w_pulse_nxt     = 1'b1;
                    w_key_state_nxt = 1'b1;
                end
            end
            ST_HELD: begin
                if (w_db_done) begin
                    w_key_state_nxt = 1'b0;
                end else if (w_hold_due) begin
                    w_pulse_nxt = 1'b1;
                end else if (repeat_en) begin
                    w_tmr_nxt = r_tmr + C_ONE;
                end
            end
            ST_REPEAT: begin
                if (w_db_done) begin
                    w_key_state_nxt = 1'b0;
                end else if (w_rep_due) begin
                    w_pulse_nxt = 1'b1;
                end else if (repeat_en) begin
                    w_tmr_nxt = r_tmr + C_ONE;
                end
            end
            default: w_key_state_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt    <= '0;
            r_tmr       <= '0;
            r_pulse     <= 1'b0;
            r_key_state <= 1'b0;
        end else begin
            r_db_cnt    <= w_db_cnt_nxt;
            r_tmr       <= w_tmr_nxt;
            r_pulse     <= w_pulse_nxt;
            r_key_state <= w_key_state_nxt;
        end
    end

    assign pulse     = r_pulse;
    assign key_state = r_key_state;

endmodule
